data_mem_ctrl: RTL and testbench

- Multi-cycle data-memory stage directly downstream of the single-cycle datapath's ALU.
- Consumes the ALU result as the byte address, the RT register value as store data, and the decoder's MemRead/MemWrite.
- Performs byte, halfword and word loads and stores with sign or zero extension.
- Stalls the CPU (holds the PC and inhibits register write) until the access completes after a fixed, parameterised latency.

---
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl.sv | 112 +++++++++++
 tb/tb_data_mem_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the CPU datapath and the multi-cycle data-memory stage.
// The master drives the ALU address, store data and decoder controls; the slave answers with load data and status.
interface data_mem_ctrl_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;

    modport master (
        output addr_i, data_i, MemRead_i, MemWrite_i, size_i, unsigned_i,
        input  data_o, stall_o, done_o, misalign_o
    );

    modport slave (
        input  addr_i, data_i, MemRead_i, MemWrite_i, size_i, unsigned_i,
        output data_o, stall_o, done_o, misalign_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory stage: byte/half/word loads and stores with a fixed access latency.
// The CPU is stalled while an access is in flight; misaligned requests are rejected with a one-cycle flag.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_idx;
    logic [1:0]     r_lane;
    logic [1:0]     r_size;
    logic           r_unsigned;
    logic           r_write;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_done;
    logic           r_misalign;
    logic [31:0]    r_mem [DEPTH_WORDS] = '{default: '0};

    logic           w_req;
    logic           w_aligned;
    logic [31:0]    w_memWord;
    logic [31:0]    w_storeWord;
    logic [31:0]    w_loadWord;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;

    assign w_req     = bus.MemRead_i | bus.MemWrite_i;
    assign w_aligned = (bus.size_i == 2'b00)
                     | ((bus.size_i == 2'b01) & ~bus.addr_i[0])
                     | (bus.size_i[1] & (bus.addr_i[1:0] == 2'b00));
    assign w_memWord = r_mem[r_idx];
    assign w_byte    = w_memWord[{r_lane, 3'b000} +: 8];
    assign w_half    = w_memWord[{r_lane[1], 4'b0000} +: 16];

    // Read-modify-write merge so a store only touches the lanes it owns
    always_comb begin
        w_storeWord = w_memWord;
        case (r_size)
            2'b00:   w_storeWord[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
            2'b01:   w_storeWord[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_storeWord = r_wdata;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_loadWord = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_loadWord = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_loadWord = w_memWord;
        endcase
    end

    // Operands are latched on acceptance so the CPU may change its inputs while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && w_aligned) begin
                        r_idx      <= bus.addr_i[AW+1:2];
                        r_lane     <= bus.addr_i[1:0];
                        r_size     <= bus.size_i;
                        r_unsigned <= bus.unsigned_i;
                        r_write    <= bus.MemWrite_i;
                        r_wdata    <= bus.data_i;
                        r_count    <= CW'(LATENCY - 1);
                        r_state    <= ACCESS;
                    end else if (w_req) begin
                        r_misalign <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end else begin
                        if (r_write) begin
                            r_mem[r_idx] <= w_storeWord;
                        end else begin
                            r_rdata <= w_loadWord;
                        end
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o    = ((r_state == IDLE) & w_req & w_aligned) | (r_state == ACCESS);
    assign bus.data_o     = r_rdata;
    assign bus.done_o     = r_done;
    assign bus.misalign_o = r_misalign;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a byte-addressed memory model predicts every output each cycle,
// and literal load results pin both the DUT and the model.
module tb_data_mem_ctrl;
    localparam int DEPTH  = 128;
    localparam int LAT    = 2;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_mem_ctrl_if busIf();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        checkEn = 1'b0;
    logic        expStall;
    logic        expDone;
    logic        expMisalign;
    logic [31:0] expData;
    logic [31:0] lastLoad;
    logic [7:0]  modelMem [NBYTES];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic int accessBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit modelAligned(input logic [31:0] addr, input logic [1:0] size);
        return (addr % accessBytes(size)) == 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int          n;
        logic [31:0] v;
        n = accessBytes(size);
        v = '0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(modelMem[int'((addr + 32'(k)) % NBYTES)]) << (8 * k));
        end
        if (!uns && n < 4 && v[8 * n - 1]) begin
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        end
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        for (int k = 0; k < accessBytes(size); k++) begin
            modelMem[int'((addr + 32'(k)) % NBYTES)] = 8'(data >> (8 * k));
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall_o", {31'b0, busIf.stall_o}, {31'b0, expStall});
            checkOutput("done_o", {31'b0, busIf.done_o}, {31'b0, expDone});
            checkOutput("misalign_o", {31'b0, busIf.misalign_o}, {31'b0, expMisalign});
            checkOutput("data_o", busIf.data_o, expData);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        busIf.addr_i     = '0;
        busIf.data_i     = '0;
        busIf.MemRead_i  = 1'b0;
        busIf.MemWrite_i = 1'b0;
        busIf.size_i     = 2'b00;
        busIf.unsigned_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            clearInputs();
            expStall    = 1'b0;
            expDone     = 1'b0;
            expMisalign = 1'b0;
            expData     = lastLoad;
        end
    endtask

    // One memory instruction as the CPU presents it: held while stalled, retired after DONE
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input bit uns, input bit rstInAccess,
                                 input bit useLit, input logic [31:0] lit, input string name);
        cycle();
        busIf.addr_i     = addr;
        busIf.data_i     = data;
        busIf.MemRead_i  = rd;
        busIf.MemWrite_i = wr;
        busIf.size_i     = size;
        busIf.unsigned_i = uns;
        expDone     = 1'b0;
        expMisalign = 1'b0;
        expData     = lastLoad;
        if (!modelAligned(addr, size)) begin
            expStall = 1'b0;
            cycle();
            clearInputs();
            expMisalign = 1'b1;
            return;
        end
        expStall = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            cycle();
            busIf.addr_i = $urandom;
            busIf.data_i = $urandom;
            expStall     = 1'b1;
            if (rstInAccess && c == 2) rst = 1'b1;
        end
        if (rstInAccess) begin
            cycle();
            rst = 1'b0;
            clearInputs();
            lastLoad = '0;
            expStall = 1'b0;
            expDone  = 1'b0;
            expData  = '0;
            return;
        end
        cycle();
        busIf.addr_i = addr;
        busIf.data_i = data;
        if (wr) modelStore(addr, size, data);
        else    lastLoad = modelLoad(addr, size, uns);
        expStall = 1'b0;
        expDone  = 1'b1;
        expData  = lastLoad;
        if (useLit) begin
            @(negedge clk);
            checkOutput({name, " literal"}, busIf.data_o, lit);
            checkOutput({name, " model"}, lastLoad, lit);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NBYTES; i++) modelMem[i] = 8'h00;
        clearInputs();
        lastLoad = '0;
        rst = 1'b1;
        cycle();
        cycle();
        rst         = 1'b0;
        expStall    = 1'b0;
        expDone     = 1'b0;
        expMisalign = 1'b0;
        expData     = '0;
        checkEn     = 1'b1;
        @(negedge clk);
        checkOutput("reset data_o", busIf.data_o, 32'h0);
        idleCycles(1);

        applyStimulus(1, 0, 32'h00, 32'h0, 2'b10, 0, 0, 1, 32'h00000000, "lw 0x00");
        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 0, 32'h0, "sw 0x10");
        applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0, 0, 1, 32'hDEADBEEF, "lw 0x10");
        applyStimulus(0, 1, 32'h13, 32'hAAAAAA80, 2'b00, 0, 0, 0, 32'h0, "sb 0x13");
        applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0, 0, 1, 32'h80ADBEEF, "lw after sb");
        applyStimulus(1, 0, 32'h13, 32'h0, 2'b00, 0, 0, 1, 32'hFFFFFF80, "lb 0x13");
        applyStimulus(1, 0, 32'h13, 32'h0, 2'b00, 1, 0, 1, 32'h00000080, "lbu 0x13");
        applyStimulus(1, 0, 32'h12, 32'h0, 2'b01, 0, 0, 1, 32'hFFFF80AD, "lh 0x12");
        applyStimulus(1, 0, 32'h10, 32'h0, 2'b01, 1, 0, 1, 32'h0000BEEF, "lhu 0x10");
        idleCycles(2);

        applyStimulus(1, 0, 32'h11, 32'h0, 2'b10, 0, 0, 0, 32'h0, "lw 0x11 misaligned");
        applyStimulus(0, 1, 32'h13, 32'h0000FFFF, 2'b01, 0, 0, 0, 32'h0, "sh 0x13 misaligned");
        idleCycles(1);
        applyStimulus(1, 0, 32'h10, 32'h0, 2'b10, 0, 0, 1, 32'h80ADBEEF, "lw 0x10 unchanged");
        idleCycles(1);

        applyStimulus(0, 1, 32'h20, 32'h12345678, 2'b10, 0, 1, 0, 32'h0, "sw 0x20 reset");
        idleCycles(2);
        applyStimulus(1, 0, 32'h20, 32'h0, 2'b10, 0, 0, 1, 32'h00000000, "lw 0x20 after reset");

        applyStimulus(1, 1, 32'h22, 32'h1234BEEF, 2'b01, 0, 0, 0, 32'h0, "read+write is sh");
        applyStimulus(1, 0, 32'h20, 32'h0, 2'b11, 0, 0, 1, 32'hBEEF0000, "size 11 load");
        applyStimulus(1, 0, 32'h22, 32'h0, 2'b01, 0, 0, 1, 32'hFFFFBEEF, "lh 0x22");

        applyStimulus(0, 1, 32'h204, 32'hCAFEF00D, 2'b10, 0, 0, 0, 32'h0, "sw 0x204");
        applyStimulus(1, 0, 32'h004, 32'h0, 2'b10, 0, 0, 1, 32'hCAFEF00D, "lw 0x004 wrap");
        idleCycles(2);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
